// File: rtl/ship_fire_ctrl.sv
// Player-ship controller: tracks heading and fire mode, and paces shots to the
// projectile stage through a valid/ready handshake with burst gaps and cooldown.
module ship_fire_ctrl #(
  parameter int HEADING_BITS = 3,
  parameter int COOLDOWN     = 4,
  parameter int BURST_LEN    = 3,
  parameter int BURST_GAP    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fire,
  input  logic                    change_mode,
  input  logic                    rotate,
  input  logic                    rotate_right,
  input  logic                    spawn_ready,
  output logic                    spawn_valid,
  output logic [HEADING_BITS-1:0] spawn_heading,
  output logic [HEADING_BITS-1:0] heading,
  output logic                    burst_mode,
  output logic                    busy
);

  localparam int MAX_A = (COOLDOWN > BURST_GAP) ? COOLDOWN : BURST_GAP;
  localparam int MAX_V = (MAX_A > BURST_LEN) ? MAX_A : BURST_LEN;
  localparam int CNT_W = $clog2(MAX_V + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOOT,
    ST_GAP,
    ST_COOLDOWN
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        shots_q;
  logic                    spawn_valid_q;
  logic [HEADING_BITS-1:0] spawn_heading_q;
  logic                    busy_q;
  logic                    burst_mode_q;
  logic [HEADING_BITS-1:0] heading_q;
  logic [HEADING_BITS-1:0] heading_d;

  // Heading wraps naturally through the fixed register width.
  always_comb begin
    heading_d = heading_q;
    if (rotate) begin
      if (rotate_right) heading_d = heading_q + HEADING_BITS'(1);
      else              heading_d = heading_q - HEADING_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) heading_q <= '0;
    else     heading_q <= heading_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      shots_q         <= '0;
      spawn_valid_q   <= 1'b0;
      spawn_heading_q <= '0;
      busy_q          <= 1'b0;
      burst_mode_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (change_mode) burst_mode_q <= ~burst_mode_q;
          // The volley length uses the mode as it stood before any same-cycle toggle.
          if (fire) begin
            state_q         <= ST_SHOOT;
            shots_q         <= burst_mode_q ? CNT_W'(BURST_LEN) : CNT_W'(1);
            spawn_heading_q <= heading_q;
            spawn_valid_q   <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        ST_SHOOT: begin
          if (spawn_valid_q && spawn_ready) begin
            spawn_valid_q <= 1'b0;
            shots_q       <= shots_q - CNT_W'(1);
            if (shots_q > CNT_W'(1)) begin
              state_q <= ST_GAP;
              cnt_q   <= CNT_W'(BURST_GAP - 1);
            end else begin
              state_q <= ST_COOLDOWN;
              cnt_q   <= CNT_W'(COOLDOWN - 1);
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_q         <= ST_SHOOT;
            spawn_valid_q   <= 1'b1;
            spawn_heading_q <= heading_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          spawn_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign spawn_valid   = spawn_valid_q;
  assign spawn_heading = spawn_heading_q;
  assign heading       = heading_q;
  assign burst_mode    = burst_mode_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ship_fire_ctrl.sv
// Scoreboard bench for ship_fire_ctrl: expected shot headings are queued when a
// volley is requested and matched against every completed handshake.
module tb_ship_fire_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire = 1'b0;
  logic       change_mode = 1'b0;
  logic       rotate = 1'b0;
  logic       rotate_right = 1'b0;
  logic       spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [2:0] spawn_heading;
  logic [2:0] heading;
  logic       burst_mode;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int shots_seen = 0;
  logic [2:0] exp_heading = 3'd0;
  logic [2:0] exp_q[$];

  ship_fire_ctrl #(
    .HEADING_BITS(3), .COOLDOWN(4), .BURST_LEN(3), .BURST_GAP(2)
  ) dut (
    .clk(clk), .rst(rst), .fire(fire), .change_mode(change_mode),
    .rotate(rotate), .rotate_right(rotate_right), .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid), .spawn_heading(spawn_heading),
    .heading(heading), .burst_mode(burst_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; a handshake visible here completes on the next posedge.
  always @(negedge clk) begin
    #1;
    if (!rst && spawn_valid && spawn_ready) begin
      shots_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_shot: got spawn_heading=%0d, required no shot", spawn_heading);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (spawn_heading !== e) begin
          failures++;
          $display("FAIL sb_shot_heading: got %0d, required %0d", spawn_heading, e);
        end
      end
    end
  end

  task automatic rot(input int n, input logic right);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rotate = 1'b1;
      rotate_right = right;
      exp_heading = right ? exp_heading + 3'd1 : exp_heading - 3'd1;
    end
    @(negedge clk);
    rotate = 1'b0;
    rotate_right = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout: got busy=%b, required 0 within 30 cycles", tag, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (heading !== 3'd0) begin failures++; $display("FAIL rst_heading: got %0d, required 0", heading); end
    checks++; if (burst_mode !== 1'b0) begin failures++; $display("FAIL rst_burst_mode: got %b, required 0", burst_mode); end
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL rst_spawn_valid: got %b, required 0", spawn_valid); end
    checks++; if (spawn_heading !== 3'd0) begin failures++; $display("FAIL rst_spawn_heading: got %0d, required 0", spawn_heading); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    exp_heading = 3'd0;
  endtask

  task automatic test_heading();
    rot(9, 1'b1);
    checks++; if (heading !== exp_heading || heading !== 3'd1) begin failures++; $display("FAIL hdg_wrap_up: got %0d, required 1", heading); end
    rot(7, 1'b1);
    checks++; if (heading !== 3'd0) begin failures++; $display("FAIL hdg_back_to_0: got %0d, required 0", heading); end
    rot(1, 1'b0);
    checks++; if (heading !== 3'd7) begin failures++; $display("FAIL hdg_wrap_down: got %0d, required 7", heading); end
    rotate_right = 1'b1;
    repeat (2) @(negedge clk);
    rotate_right = 1'b0;
    checks++; if (heading !== 3'd7) begin failures++; $display("FAIL hdg_qualifier_only: got %0d, required 7", heading); end
    rot(2, 1'b0);
    checks++; if (heading !== 3'd5) begin failures++; $display("FAIL hdg_to_5: got %0d, required 5", heading); end
  endtask

  task automatic test_single_shot();
    int busy_cnt = 0;
    int vld_cnt = 0;
    int shots0 = shots_seen;
    logic vld_first = 1'b0;
    spawn_ready = 1'b1;
    fire = 1'b1;
    exp_q.push_back(exp_heading);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      fire = (i == 2);
      if (busy) busy_cnt++;
      if (spawn_valid) vld_cnt++;
      if (i == 1) begin
        vld_first = spawn_valid;
        checks++; if (spawn_heading !== 3'd5) begin failures++; $display("FAIL single_spawn_heading: got %0d, required 5", spawn_heading); end
      end
    end
    fire = 1'b0;
    checks++; if (vld_first !== 1'b1) begin failures++; $display("FAIL single_latency: got spawn_valid=%b in cycle N+1, required 1", vld_first); end
    checks++; if (vld_cnt != 1) begin failures++; $display("FAIL single_valid_cycles: got %0d, required 1", vld_cnt); end
    checks++; if (busy_cnt != 5) begin failures++; $display("FAIL single_busy_cycles: got %0d, required 5", busy_cnt); end
    checks++; if (shots_seen - shots0 != 1) begin failures++; $display("FAIL single_fire_dropped: got %0d shots, required 1", shots_seen - shots0); end
  endtask

  task automatic test_stall();
    int shots0 = shots_seen;
    logic [2:0] h0 = exp_heading;
    spawn_ready = 1'b0;
    fire = 1'b1;
    exp_q.push_back(h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      fire = 1'b0;
      checks++; if (spawn_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_c%0d: got %b, required 1", i, spawn_valid); end
      checks++; if (spawn_heading !== h0) begin failures++; $display("FAIL stall_heading_c%0d: got %0d, required %0d", i, spawn_heading, h0); end
      rotate = (i % 2 == 1);
      rotate_right = 1'b1;
      if (rotate) exp_heading = exp_heading + 3'd1;
    end
    @(negedge clk);
    rotate = 1'b0;
    rotate_right = 1'b0;
    spawn_ready = 1'b1;
    checks++; if (heading !== exp_heading) begin failures++; $display("FAIL stall_ship_heading: got %0d, required %0d", heading, exp_heading); end
    @(negedge clk);
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_drop: got %b, required 0", spawn_valid); end
    checks++; if (shots_seen - shots0 != 1) begin failures++; $display("FAIL stall_shot_count: got %0d, required 1", shots_seen - shots0); end
    wait_idle("stall");
  endtask

  task automatic test_burst();
    logic [13:0] vld_v = '0;
    logic [13:0] busy_v = '0;
    int shots0;
    @(negedge clk);
    change_mode = 1'b1;
    @(negedge clk);
    change_mode = 1'b0;
    checks++; if (burst_mode !== 1'b1) begin failures++; $display("FAIL burst_mode_set: got %b, required 1", burst_mode); end
    shots0 = shots_seen;
    spawn_ready = 1'b1;
    fire = 1'b1;
    exp_q.push_back(exp_heading);
    exp_q.push_back(exp_heading + 3'd1);
    exp_q.push_back(exp_heading + 3'd1);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      fire = 1'b0;
      vld_v[i] = spawn_valid;
      busy_v[i] = busy;
      rotate = (i == 2);
      rotate_right = 1'b1;
      if (i == 2) exp_heading = exp_heading + 3'd1;
    end
    rotate = 1'b0;
    rotate_right = 1'b0;
    checks++; if (vld_v !== 14'b00_0000_1001_0010) begin failures++; $display("FAIL burst_valid_pattern: got %b, required %b", vld_v, 14'b00_0000_1001_0010); end
    checks++; if (busy_v !== 14'b00_1111_1111_1110) begin failures++; $display("FAIL burst_busy_pattern: got %b, required %b", busy_v, 14'b00_1111_1111_1110); end
    checks++; if (shots_seen - shots0 != 3) begin failures++; $display("FAIL burst_shot_count: got %0d, required 3", shots_seen - shots0); end
  endtask

  task automatic test_mode_busy_reset();
    logic any_vld = 1'b0;
    int shots0;
    spawn_ready = 1'b0;
    fire = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      fire = 1'b0;
      change_mode = (i == 2);
    end
    change_mode = 1'b0;
    checks++; if (burst_mode !== 1'b1) begin failures++; $display("FAIL busy_mode_ignored: got %b, required 1", burst_mode); end
    checks++; if (spawn_valid !== 1'b1) begin failures++; $display("FAIL busy_pre_rst_valid: got %b, required 1", spawn_valid); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b, required 0", spawn_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b, required 0", busy); end
    checks++; if (heading !== 3'd0) begin failures++; $display("FAIL rst_async_heading: got %0d, required 0", heading); end
    exp_heading = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    spawn_ready = 1'b1;
    shots0 = shots_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (spawn_valid) any_vld = 1'b1;
    end
    checks++; if (any_vld !== 1'b0 || shots_seen != shots0) begin failures++; $display("FAIL rst_no_spawn: got valid_seen=%b shots=%0d, required 0 and 0", any_vld, shots_seen - shots0); end
  endtask

  task automatic test_fire_and_mode();
    int shots0 = shots_seen;
    spawn_ready = 1'b1;
    fire = 1'b1;
    change_mode = 1'b1;
    exp_q.push_back(exp_heading);
    @(negedge clk);
    fire = 1'b0;
    change_mode = 1'b0;
    wait_idle("fire_mode");
    checks++; if (burst_mode !== 1'b1) begin failures++; $display("FAIL fire_mode_toggle: got %b, required 1", burst_mode); end
    checks++; if (shots_seen - shots0 != 1) begin failures++; $display("FAIL fire_mode_old_mode: got %0d shots, required 1", shots_seen - shots0); end
  endtask

  initial begin
    test_reset();
    test_heading();
    test_single_shot();
    test_stall();
    test_burst();
    test_mode_busy_reset();
    test_fire_and_mode();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending shots, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
